echo_engine: RTL

ECHO_ENGINE -- requirements
Module: echo_engine

---
 rtl/echo_pkg.sv | 21 ++
 rtl/echo_ram.sv | 29 ++
 rtl/echo_engine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// Shared types and constants for the echo engine: sequencer states,
// mode encodings and the default ADC/DAC offsets.
package echo_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_CALC  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam logic [1:0] MODE_BYPASS   = 2'b00;
  localparam logic [1:0] MODE_FEEDBACK = 2'b01;
  localparam logic [1:0] MODE_FEEDFWD  = 2'b10;
  localparam logic [1:0] MODE_MUTE     = 2'b11;

  localparam logic [9:0] DEF_ADC_OFFSET = 10'h181;
  localparam logic [9:0] DEF_DAC_OFFSET = 10'h200;

endpackage

// File: rtl/echo_ram.sv
// Simple dual-port delay memory: one write port, one read port with a
// single cycle of read latency. A same-address read and write in the same
// cycle returns the previous contents.
module echo_ram #(
  parameter int DW = 10,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Storage write and registered read; non-blocking update gives read-old-data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/echo_engine.sv
// Echo engine: removes the ADC offset from each incoming sample, mixes in an
// attenuated delayed copy from the delay memory (feedback or feed-forward),
// saturates, and emits the result with the DAC offset restored. The delay
// memory is cleared to zero after every reset.
module echo_engine
  import echo_pkg::*;
#(
  parameter int            DW         = 10,
  parameter int            AW         = 13,
  parameter int            DLY_W      = 9,
  parameter int            DLY_SHIFT  = 4,
  parameter logic [DW-1:0] ADC_OFFSET = DW'(DEF_ADC_OFFSET),
  parameter logic [DW-1:0] DAC_OFFSET = DW'(DEF_DAC_OFFSET)
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [DW-1:0]    data_in,
  input  logic             data_valid,
  input  logic [DLY_W-1:0] delay_sel,
  input  logic [1:0]       gain_sel,
  input  logic [1:0]       mode,
  output logic [DW-1:0]    data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  state_t           state;
  logic             dv_r;
  logic             strobe;
  logic [AW-1:0]    clr_addr;
  logic [AW-1:0]    rd_ptr;
  logic [DW-1:0]    x_r;
  logic [DW-1:0]    y_r;
  logic [DLY_W-1:0] dly_r;
  logic [1:0]       gain_r;
  logic [1:0]       mode_r;
  logic [DW-1:0]    q;
  logic [DW-1:0]    e_s;
  logic [DW:0]      diff_s;
  logic [DW-1:0]    y_sat_s;
  logic [AW-1:0]    wr_addr_s;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [DW-1:0]    ram_wdata;
  logic             ram_re;

  assign strobe    = data_valid & ~dv_r;
  assign wr_addr_s = rd_ptr + AW'({dly_r, {DLY_SHIFT{1'b0}}});
  assign ram_re    = (state == ST_READ) && !reset;

  // Echo term and saturated difference y = x - e, clamped to the signed DW range.
  always_comb begin
    e_s = '0;
    if (dly_r != '0) begin
      e_s = DW'($signed(q) >>> ({1'b0, gain_r} + 3'd1));
    end else begin
      e_s = '0;
    end
    diff_s = {x_r[DW-1], x_r} - {e_s[DW-1], e_s};
    if (diff_s[DW] != diff_s[DW-1]) begin
      y_sat_s = diff_s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      y_sat_s = diff_s[DW-1:0];
    end
  end

  // Delay-memory write port: zero-fill while clearing, sample store in WRITE.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr;
    ram_wdata = '0;
    if (reset) begin
      ram_we = 1'b0;
    end else if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end else if (state == ST_WRITE) begin
      ram_we    = 1'b1;
      ram_waddr = wr_addr_s;
      ram_wdata = (mode_r == MODE_FEEDBACK) ? y_r : x_r;
    end else begin
      ram_we = 1'b0;
    end
  end

  echo_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk    (sysclk),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(ram_wdata),
    .rd_en  (ram_re),
    .rd_addr(rd_ptr),
    .rd_data(q)
  );

  // Sample sequencer with registered outputs, edge detect and overrun flag.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_addr  <= '0;
      rd_ptr    <= '0;
      dv_r      <= 1'b1;
      data_out  <= DAC_OFFSET;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b1;
      x_r       <= '0;
      y_r       <= '0;
      dly_r     <= '0;
      gain_r    <= 2'b00;
      mode_r    <= MODE_BYPASS;
    end else begin
      dv_r      <= data_valid;
      out_valid <= 1'b0;
      if (strobe && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (strobe) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          x_r    <= data_in - ADC_OFFSET;
          dly_r  <= delay_sel;
          gain_r <= gain_sel;
          mode_r <= mode;
          state  <= ST_CALC;
        end
        ST_CALC: begin
          y_r   <= y_sat_s;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          case (mode_r)
            MODE_BYPASS:   data_out <= x_r + DAC_OFFSET;
            MODE_FEEDBACK: data_out <= y_r + DAC_OFFSET;
            MODE_FEEDFWD:  data_out <= y_r + DAC_OFFSET;
            MODE_MUTE:     data_out <= DAC_OFFSET;
            default:       data_out <= DAC_OFFSET;
          endcase
          out_valid <= 1'b1;
          rd_ptr    <= rd_ptr + AW'(1);
          state     <= ST_IDLE;
        end
        default: begin
          state    <= ST_CLEAR;
          clr_addr <= '0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule
